load_store_unit: RTL and testbench

Multi-cycle load/store unit between the core's memory-stage request and the word-organised data memory (64 × 32-bit; word-indexed address; sync write, async read). Converts byte-addressed RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses:
- sub-word stores become single-cycle read-modify-writes;
- misaligned accesses are split into two word accesses;
- load results are returned extracted and sign- or zero-extended.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane_align.sv | 72 +++++++
 rtl/load_store_unit.sv | 126 ++++++++++++
 tb/tb_load_store_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request-decode helpers for the load/store unit.
package lsu_pkg;

    localparam int LSU_WIDTH = 32;
    localparam int LSU_ADDR  = 32;
    localparam int BYTES     = LSU_WIDTH / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    // Access size in bytes; the unsigned variants share the size of their signed twins.
    function automatic logic [2:0] lsu_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic lsu_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            return !(funct3 inside {F3_B, F3_H, F3_W});
        return funct3 inside {3'b011, 3'b110, 3'b111};
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store merge into a memory word and load extraction/extension.
// Latency: purely combinational.
// Backpressure: none, stateless.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic        sel,
    input  logic [31:0] rd,
    output logic [3:0]  lane_mask,
    output logic [31:0] merged,
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    // The store is placed into an 8-byte window {word1, word0}; sel picks which half is written now.
    function automatic logic [35:0] store_lanes(
        input logic [31:0] data_in,
        input logic [1:0]  byte_off,
        input logic [2:0]  nbytes,
        input logic        hi_word,
        input logic [31:0] old_word
    );
        logic [63:0] shifted;
        logic [7:0]  mask8;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [31:0] word;
        shifted = {32'b0, data_in} << {byte_off, 3'b000};
        case (nbytes)
            3'd1:    mask8 = 8'b0000_0001;
            3'd2:    mask8 = 8'b0000_0011;
            default: mask8 = 8'b0000_1111;
        endcase
        mask8 = mask8 << byte_off;
        mask  = hi_word ? mask8[7:4] : mask8[3:0];
        data  = hi_word ? shifted[63:32] : shifted[31:0];
        word  = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i])
                word[8*i +: 8] = data[8*i +: 8];
        end
        return {mask, word};
    endfunction

    function automatic logic [31:0] load_extract(
        input logic [63:0] pair,
        input logic [1:0]  byte_off,
        input logic [2:0]  f3
    );
        logic [31:0] s;
        s = 32'(pair >> {byte_off, 3'b000});
        case (f3)
            F3_B:    return {{24{s[7]}}, s[7:0]};
            F3_H:    return {{16{s[15]}}, s[15:0]};
            F3_W:    return s;
            F3_BU:   return {24'b0, s[7:0]};
            F3_HU:   return {16'b0, s[15:0]};
            default: return 32'b0;
        endcase
    endfunction

    always_comb begin
        {lane_mask, merged} = store_lanes(wdata, off, size, sel, rd);
        rdata               = load_extract({w1, w0}, off, funct3);
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store to word memory: RMW sub-word stores, split misaligned accesses.
// Latency: accept at edge N -> rsp_valid in cycle N+2 (N+3 crossing, N+1 illegal funct3).
// Backpressure: req_ready only in IDLE; responses are a one-cycle pulse and cannot be stalled.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int width         = LSU_WIDTH,
    parameter int address_lines = LSU_ADDR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [address_lines-1:0] req_addr,
    input  logic [width-1:0]         req_wdata,
    output logic                     rsp_valid,
    output logic [width-1:0]         rsp_rdata,
    output logic                     rsp_err,
    output logic [address_lines-1:0] mem_A,
    output logic                     mem_WE,
    output logic [width-1:0]         mem_WD,
    input  logic [width-1:0]         mem_RD
);

    localparam int WORD_BITS = address_lines - 2;

    state_t                   state_q;
    state_t                   state_d;
    logic                     we_q;
    logic [2:0]               funct3_q;
    logic [address_lines-1:0] addr_q;
    logic [width-1:0]         wdata_q;
    logic [width-1:0]         w0_q;

    logic [2:0]               size_q;
    logic                     crosses;
    logic [WORD_BITS-1:0]     word0;
    logic [WORD_BITS-1:0]     word1;
    logic                     store_cycle;
    logic [3:0]               lane_mask;
    logic [width-1:0]         merged;
    logic [width-1:0]         load_lo;
    logic [width-1:0]         load_hi;
    logic [width-1:0]         load_data;

    assign size_q  = lsu_size(funct3_q);
    assign crosses = ({2'b00, addr_q[1:0]} + {1'b0, size_q}) > 4'(BYTES);
    assign word0   = addr_q[address_lines-1:2];
    assign word1   = word0 + WORD_BITS'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid)
                    state_d = lsu_illegal(req_we, req_funct3) ? RESP : ACC0;
            end
            ACC0:    state_d = crosses ? ACC1 : RESP;
            ACC1:    state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // In ACC0 the first word is still on mem_RD; in ACC1 it comes from w0_q and mem_RD is the second word.
    assign load_lo = (state_q == ACC1) ? w0_q : mem_RD;
    assign load_hi = (state_q == ACC1) ? mem_RD : '0;

    lsu_lane_align u_align (
        .wdata     (wdata_q),
        .off       (addr_q[1:0]),
        .size      (size_q),
        .sel       (state_q == ACC1),
        .rd        (mem_RD),
        .lane_mask (lane_mask),
        .merged    (merged),
        .w0        (load_lo),
        .w1        (load_hi),
        .funct3    (funct3_q),
        .rdata     (load_data)
    );

    assign req_ready   = (state_q == IDLE);
    assign store_cycle = we_q && ((state_q == ACC0) || (state_q == ACC1));
    assign mem_WE      = store_cycle && (|lane_mask);
    assign mem_WD      = mem_WE ? merged : '0;

    always_comb begin
        mem_A = '0;
        case (state_q)
            ACC0:    mem_A = {2'b00, word0};
            ACC1:    mem_A = {2'b00, word1};
            default: mem_A = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            w0_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_ready && req_valid) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state_q == ACC0)
                w0_q <= mem_RD;
            // Entering RESP straight from IDLE only happens for an illegal funct3.
            rsp_valid <= (state_d == RESP);
            rsp_err   <= (state_d == RESP) && (state_q == IDLE);
            rsp_rdata <= ((state_d == RESP) && (state_q != IDLE) && !we_q) ? load_data : '0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word behavioural memory and backdoor preload.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_A;
    logic        mem_WE;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    logic [31:0] mem [64];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = '0;
    logic [31:0] bd_dat = '0;

    int checks = 0;
    int errors = 0;
    int rsp_cnt = 0;

    int          lat;
    int          wes;
    int          na;
    logic [31:0] a_seq [4];
    logic [31:0] got_rd;
    logic        got_err;
    logic        pulse_after;
    logic        rdy_after;
    int          rsp_before;

    load_store_unit #(.width(32), .address_lines(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_A      (mem_A),
        .mem_WE     (mem_WE),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
    );

    always #5 clk = ~clk;

    assign mem_RD = mem[mem_A[5:0]];

    always @(posedge clk) begin
        if (mem_WE)
            mem[mem_A[5:0]] <= mem_WD;
        else if (bd_we)
            mem[bd_idx] <= bd_dat;
        if (rsp_valid)
            rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
        bd_we  = 1'b1;
        bd_idx = idx;
        bd_dat = val;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // Issues one request, then follows it to its response pulse (bounded to 6 cycles).
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        wes = 0;
        na  = 0;
        got_rd  = 'x;
        got_err = 1'bx;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_WE)
                wes++;
            if (rsp_valid) begin
                lat     = k;
                got_rd  = rsp_rdata;
                got_err = rsp_err;
            end else if (na < 4) begin
                a_seq[na] = mem_A;
                na++;
            end
        end
        @(negedge clk);
        pulse_after = rsp_valid;
        rdy_after   = req_ready;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;

        #12;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_mem_WE", {31'b0, mem_WE}, 32'd0);
        check("rst_mem_A", mem_A, 32'd0);
        check("rst_mem_WD", mem_WD, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);

        // Aligned word store then load.
        run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        check("sw_lat", lat, 2);
        check("sw_we_pulses", wes, 1);
        check("sw_mem_A", a_seq[0], 32'd4);
        check("sw_mem4", mem[4], 32'hDEADBEEF);
        check("sw_rdata", got_rd, 32'd0);
        check("sw_err", {31'b0, got_err}, 32'd0);
        check("sw_pulse_len", {31'b0, pulse_after}, 32'd0);
        check("sw_ready_after", {31'b0, rdy_after}, 32'd1);
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_lat", lat, 2);
        check("lw_rdata", got_rd, 32'hDEADBEEF);
        check("lw_we_pulses", wes, 0);

        // Sub-word store read-modify-write and sign/zero extension.
        poke(6'd4, 32'h0);
        run_req(1'b1, 3'b000, 32'h11, 32'h00000080);
        check("sb_lat", lat, 2);
        check("sb_mem4", mem[4], 32'h00008000);
        run_req(1'b0, 3'b000, 32'h11, 32'h0);
        check("lb_rdata", got_rd, 32'hFFFFFF80);
        run_req(1'b0, 3'b100, 32'h11, 32'h0);
        check("lbu_rdata", got_rd, 32'h00000080);

        // Misaligned word load across words 4 and 5.
        poke(6'd4, 32'h44332211);
        poke(6'd5, 32'h88776655);
        run_req(1'b0, 3'b010, 32'h13, 32'h0);
        check("lw_x_lat", lat, 3);
        check("lw_x_rdata", got_rd, 32'h77665544);
        check("lw_x_A0", a_seq[0], 32'd4);
        check("lw_x_A1", a_seq[1], 32'd5);
        check("lw_x_we_pulses", wes, 0);
        run_req(1'b0, 3'b001, 32'h13, 32'h0);
        check("lh_x_rdata", got_rd, 32'h00005544);
        run_req(1'b0, 3'b101, 32'h12, 32'h0);
        check("lhu_rdata", got_rd, 32'h00004433);

        // Misaligned half store across words 5 and 6.
        poke(6'd5, 32'h0);
        poke(6'd6, 32'h0);
        run_req(1'b1, 3'b001, 32'h17, 32'h0000ABCD);
        check("sh_x_lat", lat, 3);
        check("sh_x_we_pulses", wes, 2);
        check("sh_x_mem5", mem[5], 32'hCD000000);
        check("sh_x_mem6", mem[6], 32'h000000AB);

        // Illegal funct3 for a load and for a store.
        run_req(1'b0, 3'b011, 32'h10, 32'h0);
        check("err_ld_lat", lat, 1);
        check("err_ld_err", {31'b0, got_err}, 32'd1);
        check("err_ld_rdata", got_rd, 32'd0);
        check("err_ld_we", wes, 0);
        run_req(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
        check("err_st_lat", lat, 1);
        check("err_st_err", {31'b0, got_err}, 32'd1);
        check("err_st_we", wes, 0);
        check("err_st_mem4", mem[4], 32'h44332211);

        // Crossing store aborted by reset while in ACC1.
        poke(6'd7, 32'h11111111);
        poke(6'd8, 32'h12345678);
        rsp_before = rsp_cnt;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h1E;
        req_wdata  = 32'hCAFEF00D;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("abort_acc0_A", mem_A, 32'd7);
        check("abort_acc0_WE", {31'b0, mem_WE}, 32'd1);
        @(posedge clk);
        #1;
        check("abort_acc1_A", mem_A, 32'd8);
        rst_n = 1'b0;
        #1;
        check("abort_WE_low", {31'b0, mem_WE}, 32'd0);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_rsp", rsp_cnt - rsp_before, 0);
        check("abort_ready_after", {31'b0, req_ready}, 32'd1);
        check("abort_mem7", mem[7], 32'hF00D1111);
        check("abort_mem8", mem[8], 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
